// File: rtl/id_ex_stage.sv
`default_nettype none
// id_ex_stage: ID/EX pipeline register with load-use hazard detection and MEM/WB operand forwarding.
// Macro ID_EX_FORWARDING_EN enables forwarding; without it, RAW hazards stall ID until the producer reaches WB.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic        id_alu_src,
    input  logic [3:0]  id_alu_ctrl,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        flush,
    input  logic        hold,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_result,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_result,
    output logic        id_stall,
    output logic        ex_valid,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_store_data,
    output logic [3:0]  ex_alu_ctrl,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic        alu_src;
        logic [3:0]  alu_ctrl;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } ex_reg_t;

    ex_reg_t     ex_q;
    ex_reg_t     ex_d;
    ex_reg_t     id_word;
    logic        hazard;
    logic        rs_hit_ex;
    logic        rt_hit_ex;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    always_comb begin
        rs_hit_ex = id_use_rs && (id_rs == ex_q.rd);
        rt_hit_ex = id_use_rt && (id_rt == ex_q.rd);
    end

`ifdef ID_EX_FORWARDING_EN
    logic load_in_ex;

    // Only a load in EX cannot be forwarded in time; everything else is covered by the muxes below.
    always_comb begin
        load_in_ex = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0);
        hazard     = id_valid && load_in_ex && (rs_hit_ex || rt_hit_ex);
    end

    always_comb begin
        fwd_rs = ex_q.rs_data;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_q.rs)) begin
            fwd_rs = mem_result;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_q.rs)) begin
            fwd_rs = wb_result;
        end
        fwd_rt = ex_q.rt_data;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_q.rt)) begin
            fwd_rt = mem_result;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_q.rt)) begin
            fwd_rt = wb_result;
        end
    end
`else
    logic ex_producer;
    logic mem_producer;
    logic rs_hit_mem;
    logic rt_hit_mem;
    logic unused_fwd_inputs;

    // WB needs no check: the register file writes early enough for ID to read the new value.
    always_comb begin
        ex_producer  = ex_q.valid && (ex_q.reg_write || ex_q.mem_read) && (ex_q.rd != 5'd0);
        mem_producer = mem_reg_write && (mem_rd != 5'd0);
        rs_hit_mem   = id_use_rs && (id_rs == mem_rd);
        rt_hit_mem   = id_use_rt && (id_rt == mem_rd);
        hazard       = id_valid && ((ex_producer && (rs_hit_ex || rt_hit_ex)) ||
                                    (mem_producer && (rs_hit_mem || rt_hit_mem)));
    end

    assign fwd_rs = ex_q.rs_data;
    assign fwd_rt = ex_q.rt_data;
    assign unused_fwd_inputs = ^{wb_reg_write, wb_rd, wb_result, mem_result, ex_q.rs, ex_q.rt};
`endif

    assign id_stall = hazard || hold;

    always_comb begin
        id_word           = '0;
        id_word.valid     = id_valid;
        id_word.rs        = id_rs;
        id_word.rt        = id_rt;
        id_word.rs_data   = id_rs_data;
        id_word.rt_data   = id_rt_data;
        id_word.imm       = id_imm;
        id_word.alu_src   = id_alu_src;
        id_word.alu_ctrl  = id_alu_ctrl;
        id_word.rd        = id_rd;
        id_word.reg_write = id_reg_write;
        id_word.mem_read  = id_mem_read;
        id_word.mem_write = id_mem_write;
    end

    // Flush outranks hold so a squashed instruction never lingers in a frozen EX.
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (hold) begin
            ex_d = ex_q;
        end else if (hazard) begin
            ex_d = '0;
        end else begin
            ex_d = id_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_a          = fwd_rs;
    assign ex_b          = ex_q.alu_src ? ex_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_alu_ctrl   = ex_q.alu_ctrl;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// tb_id_ex_stage: directed instruction stream against a behavioural EX/MEM/WB model, compared every cycle.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        use_rs;
        logic        use_rt;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic        alu_src;
        logic [3:0]  alu_ctrl;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } stage_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    stage_t      id = '0;
    stage_t      m = '0;
    logic        mem_reg_write = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_result = '0;
    logic        mem_load = 1'b0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_result = '0;
    logic        manual = 1'b0;
    logic [31:0] rf [32];
    int          compared = 0;
    int          mismatched = 0;

    logic        id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_alu_ctrl;
    logic [4:0]  ex_rd;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id.valid), .id_rs(id.rs), .id_rt(id.rt),
        .id_use_rs(id.use_rs), .id_use_rt(id.use_rt),
        .id_rs_data(id.rs_data), .id_rt_data(id.rt_data), .id_imm(id.imm),
        .id_alu_src(id.alu_src), .id_alu_ctrl(id.alu_ctrl), .id_rd(id.rd),
        .id_reg_write(id.reg_write), .id_mem_read(id.mem_read), .id_mem_write(id.mem_write),
        .flush(flush), .hold(hold),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_store_data(ex_store_data), .ex_alu_ctrl(ex_alu_ctrl), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Value an instruction in EX sees for register r whose ID-time read was regval.
    function automatic logic [31:0] fwdv(input logic [4:0] r, input logic [31:0] regval);
        if (FWD && r != 5'd0 && mem_reg_write && mem_rd == r) return mem_result;
        if (FWD && r != 5'd0 && wb_reg_write && wb_rd == r) return wb_result;
        return regval;
    endfunction

    function automatic logic reads(input logic [4:0] r);
        return (r != 5'd0) && id.valid && ((id.use_rs && id.rs == r) || (id.use_rt && id.rt == r));
    endfunction

    function automatic logic exp_hazard();
        if (FWD) return m.valid && m.mem_read && reads(m.rd);
        return (m.valid && (m.reg_write || m.mem_read) && reads(m.rd)) ||
               (mem_reg_write && reads(mem_rd));
    endfunction

    function automatic logic exp_stall();
        return hold || exp_hazard();
    endfunction

    function automatic logic [31:0] rd_rf(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (wb_reg_write && wb_rd == r) return wb_result;
        return rf[r];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset)            m = '0;
        else if (flush)        m = '0;
        else if (hold)         m = m;
        else if (exp_hazard()) m = '0;
        else                   m = id;
    end

    always @(negedge clk) begin
        chk("id_stall", 32'(id_stall), 32'(exp_stall()));
        chk("ex_valid", 32'(ex_valid), 32'(m.valid));
        chk("ex_a", ex_a, fwdv(m.rs, m.rs_data));
        chk("ex_b", ex_b, m.alu_src ? m.imm : fwdv(m.rt, m.rt_data));
        chk("ex_store_data", ex_store_data, fwdv(m.rt, m.rt_data));
        chk("ex_alu_ctrl", 32'(ex_alu_ctrl), 32'(m.alu_ctrl));
        chk("ex_rd", 32'(ex_rd), 32'(m.rd));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(m.reg_write));
        chk("ex_mem_read", 32'(ex_mem_read), 32'(m.mem_read));
        chk("ex_mem_write", 32'(ex_mem_write), 32'(m.mem_write));
    end

    function automatic stage_t alu_op(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [3:0] ctrl);
        stage_t s;
        s = '0;
        s.valid = 1'b1; s.rs = rs; s.rt = rt; s.use_rs = 1'b1; s.use_rt = 1'b1;
        s.alu_ctrl = ctrl; s.rd = rd; s.reg_write = 1'b1;
        return s;
    endfunction

    function automatic stage_t load_op(input logic [4:0] rd, input logic [4:0] base, input logic [31:0] off);
        stage_t s;
        s = '0;
        s.valid = 1'b1; s.rs = base; s.use_rs = 1'b1; s.imm = off; s.alu_src = 1'b1;
        s.alu_ctrl = ALU_ADD; s.rd = rd; s.reg_write = 1'b1; s.mem_read = 1'b1;
        return s;
    endfunction

    task automatic refresh();
        id.rs_data = rd_rf(id.rs);
        id.rt_data = rd_rf(id.rt);
    endtask

    task automatic drive(input stage_t x);
        id = x;
        refresh();
    endtask

    task automatic clear_pipe();
        mem_reg_write = 1'b0; mem_rd = '0; mem_result = '0; mem_load = 1'b0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;
    endtask

    // One clock; unless driven by hand, MEM/WB advance and loads return address + 0x10.
    task automatic tick();
        stage_t      snap;
        logic [31:0] a, b, res;
        logic        frz;
        snap = m;
        frz  = hold;
        a    = fwdv(snap.rs, snap.rs_data);
        b    = snap.alu_src ? snap.imm : fwdv(snap.rt, snap.rt_data);
        res  = (snap.alu_ctrl == ALU_SUB) ? a - b : a + b;
        @(posedge clk);
        #1;
        if (!manual && !frz && reset) begin
            if (wb_reg_write && wb_rd != 5'd0) rf[wb_rd] = wb_result;
            wb_reg_write  = mem_reg_write;
            wb_rd         = mem_rd;
            wb_result     = mem_load ? mem_result + 32'h10 : mem_result;
            mem_reg_write = snap.valid && snap.reg_write;
            mem_rd        = snap.rd;
            mem_result    = res;
            mem_load      = snap.valid && snap.mem_read;
        end
        refresh();
        #1;
    endtask

    task automatic issue(input stage_t x, output int stalls);
        drive(x);
        stalls = 0;
        while (exp_stall() && stalls < 8) begin
            tick();
            stalls++;
            chk("stall_bubble", 32'(ex_valid), 32'h0);
        end
        chk("stall_bound", 32'(stalls < 8), 32'h1);
        tick();
        drive('0);
        #1;
    endtask

    initial begin
        int st;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[1] = 32'd2; rf[7] = 32'd5; rf[8] = 32'd7; rf[6] = 32'h66;

        repeat (2) tick();
        chk("reset_ex_valid", 32'(ex_valid), 32'h0);
        chk("reset_ex_a", ex_a, 32'h0);
        chk("reset_alu_ctrl", 32'(ex_alu_ctrl), 32'h0);
        chk("reset_stall", 32'(id_stall), 32'h0);
        reset = 1'b1;
        tick();

        issue(alu_op(5'd3, 5'd7, 5'd8, ALU_ADD), st);
        chk("add_ex_a", ex_a, 32'd5);
        chk("add_ex_b", ex_b, 32'd7);
        issue(alu_op(5'd4, 5'd3, 5'd1, ALU_SUB), st);
        chk("sub_stalls", 32'(st), FWD ? 32'd0 : 32'd2);
        chk("sub_ex_a", ex_a, 32'd12);
        chk("sub_ex_b", ex_b, 32'd2);
        chk("sub_alu_result", ex_a - ex_b, 32'd10);
        chk("sub_ctrl", 32'(ex_alu_ctrl), 32'(ALU_SUB));

        issue(load_op(5'd2, 5'd0, 32'd0), st);
        chk("lw_stalls", 32'(st), 32'd0);
        issue(alu_op(5'd5, 5'd2, 5'd2, ALU_ADD), st);
        chk("lu_stalls", 32'(st), FWD ? 32'd1 : 32'd2);
        chk("lu_ex_a", ex_a, 32'h10);
        chk("lu_ex_b", ex_b, 32'h10);

        issue(load_op(5'd2, 5'd0, 32'd4), st);
        issue(load_op(5'd2, 5'd0, 32'd8), st);
        chk("lw2_stalls", 32'(st), 32'd0);
        issue(alu_op(5'd14, 5'd2, 5'd0, ALU_ADD), st);
        chk("lw2_use_stalls", 32'(st), FWD ? 32'd1 : 32'd2);
        chk("lw2_use_ex_a", ex_a, 32'h18);

        manual = 1'b1;
        clear_pipe();
        issue(alu_op(5'd7, 5'd6, 5'd6, ALU_ADD), st);
        mem_reg_write = 1'b1; mem_rd = 5'd6; mem_result = 32'hAA;
        wb_reg_write = 1'b1; wb_rd = 5'd6; wb_result = 32'hBB;
        drive(alu_op(5'd8, 5'd0, 5'd6, ALU_ADD));
        #1;
        chk("prio_ex_a", ex_a, FWD ? 32'hAA : 32'h66);
        chk("prio_store", ex_store_data, FWD ? 32'hAA : 32'h66);
        chk("prio_stall", 32'(id_stall), FWD ? 32'h0 : 32'h1);
        mem_reg_write = 1'b0;
        #1;
        chk("wb_ex_a", ex_a, FWD ? 32'hBB : 32'h66);
        tick();

        mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'hFFFF_FFFF;
        wb_reg_write = 1'b0;
        drive(alu_op(5'd9, 5'd0, 5'd0, ALU_ADD));
        #1;
        chk("r0_stall", 32'(id_stall), 32'h0);
        tick();
        chk("r0_ex_a", ex_a, 32'h0);
        chk("r0_ex_b", ex_b, 32'h0);

        clear_pipe();
        drive(alu_op(5'd10, 5'd1, 5'd1, ALU_ADD));
        tick();
        drive(alu_op(5'd11, 5'd1, 5'd1, ALU_ADD));
        hold = 1'b1;
        tick();
        chk("hold_ex_rd", 32'(ex_rd), 32'd10);
        chk("hold_ex_valid", 32'(ex_valid), 32'h1);
        drive(load_op(5'd12, 5'd0, 32'd0));
        flush = 1'b1;
        tick();
        chk("fh_ex_valid", 32'(ex_valid), 32'h0);
        chk("fh_reg_write", 32'(ex_reg_write), 32'h0);
        chk("fh_mem_read", 32'(ex_mem_read), 32'h0);
        chk("fh_mem_write", 32'(ex_mem_write), 32'h0);
        flush = 1'b0;
        hold = 1'b0;

        manual = 1'b0;
        clear_pipe();
        issue(load_op(5'd2, 5'd0, 32'd0), st);
        drive(alu_op(5'd13, 5'd2, 5'd0, ALU_ADD));
        #1;
        chk("pre_reset_stall", 32'(id_stall), 32'h1);
        reset = 1'b0;
        clear_pipe();
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'h0);
        chk("rst_mem_read", 32'(ex_mem_read), 32'h0);
        chk("rst_reg_write", 32'(ex_reg_write), 32'h0);
        chk("rst_stall", 32'(id_stall), 32'h0);
        chk("rst_ex_a", ex_a, 32'h0);
        tick();
        reset = 1'b1;
        drive('0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
